// File: rtl/sys_call_ctrl_pkg.sv
// Shared types and constants for the system-call sequencer.
package sys_ctrl_pkg;

  localparam int unsigned CODE_W    = 3;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TMO_CTR_W = 16;

  // Call codes (funct3 of the sys instruction)
  localparam logic [CODE_W-1:0] SYS_PUTC = 3'b000;
  localparam logic [CODE_W-1:0] SYS_EXIT = 3'b001;
  localparam logic [CODE_W-1:0] SYS_GETC = 3'b010;

  // Result returned to EX when the host never answers
  localparam logic [DATA_W-1:0] SYS_ERR_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sys_state_e;

  // Latched request payload presented to the host
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [DATA_W-1:0] arg0;
    logic [DATA_W-1:0] arg1;
  } sys_req_t;

endpackage

// File: rtl/sys_call_ctrl_if.sv
// EX-side and host-side signals of the system-call sequencer.
interface sys_call_ctrl_if
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  // EX stage
  logic              EX__sys_req;
  logic [CODE_W-1:0] EX__sys_code;
  logic [DATA_W-1:0] EX__sys_arg0;
  logic [DATA_W-1:0] EX__sys_arg1;
  logic              EX__adv;
  logic              sys__EX_done;
  logic [DATA_W-1:0] sys__EX_result;
  logic              sys__EX_err;
  // Host system port
  logic              host_req_valid;
  logic              host_req_ready;
  logic [CODE_W-1:0] host_req_code;
  logic [DATA_W-1:0] host_req_arg0;
  logic [DATA_W-1:0] host_req_arg1;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rsp_data;
  logic              host_rsp_ready;
  // Status
  logic              sys_busy;
  logic [CNT_W-1:0]  sys_call_count;

  // Controller view
  modport master (
    input  EX__sys_req, EX__sys_code, EX__sys_arg0, EX__sys_arg1, EX__adv,
    output sys__EX_done, sys__EX_result, sys__EX_err,
    output host_req_valid, host_req_code, host_req_arg0, host_req_arg1,
    input  host_req_ready,
    input  host_rsp_valid, host_rsp_data,
    output host_rsp_ready,
    output sys_busy, sys_call_count
  );

  // Pipeline / host environment view
  modport slave (
    output EX__sys_req, EX__sys_code, EX__sys_arg0, EX__sys_arg1, EX__adv,
    input  sys__EX_done, sys__EX_result, sys__EX_err,
    input  host_req_valid, host_req_code, host_req_arg0, host_req_arg1,
    output host_req_ready,
    output host_rsp_valid, host_rsp_data,
    input  host_rsp_ready,
    input  sys_busy, sys_call_count
  );
endinterface

// File: rtl/sys_timeout_ctr.sv
// Per-call cycle counter; flags when the call has used its cycle allowance.
module sys_timeout_ctr
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);
  localparam logic [TMO_CTR_W-1:0] LIMIT = TMO_CTR_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CTR_W-1:0] r_cnt;

  // Count active cycles, parking at the limit so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + TMO_CTR_W'(1);
    end
  end

  assign o_expired_c = (r_cnt == LIMIT);
endmodule

// File: rtl/sys_call_ctrl.sv
// Sequences a sys instruction from EX through a host request/response
// transaction, with abort on timeout, and hands result/err back to EX.
module sys_call_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input logic            clk,
  input logic            rst_n,
  sys_call_ctrl_if.master bus
);
  sys_state_e         r_state;
  sys_req_t           r_req;
  logic               r_req_valid;
  logic               r_rsp_ready;
  logic               r_done;
  logic               r_err;
  logic               r_busy;
  logic [DATA_W-1:0]  r_result;
  logic [CNT_W-1:0]   r_count;

  logic w_active;
  logic w_tmo_clr;
  logic w_expired;
  logic w_rsp_take;
  logic w_abort;
  logic w_finish;

  assign w_active  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_tmo_clr = !w_active;

  sys_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_tmo_clr),
    .i_en       (w_active),
    .o_expired_c(w_expired)
  );

  // A response in WAIT beats a coincident timeout
  assign w_rsp_take = (r_state == ST_WAIT) && bus.host_rsp_valid;
  assign w_abort    = w_active && w_expired && !w_rsp_take;
  assign w_finish   = w_rsp_take || w_abort;

  // Call sequencer: state, holding registers, registered outputs, call counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_req_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_count     <= '0;
    end else if (w_finish) begin
      r_state     <= ST_DONE;
      r_req_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_done      <= 1'b1;
      r_result    <= w_rsp_take ? bus.host_rsp_data : SYS_ERR_RESULT;
      r_err       <= w_abort;
      if (r_count != '1) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.EX__sys_req) begin
            r_state     <= ST_ISSUE;
            r_req       <= '{code: bus.EX__sys_code,
                             arg0: bus.EX__sys_arg0,
                             arg1: bus.EX__sys_arg1};
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (bus.host_req_ready) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
        end
        ST_DONE: begin
          if (bus.EX__adv) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.sys__EX_done   = r_done;
  assign bus.sys__EX_result = r_result;
  assign bus.sys__EX_err    = r_err;
  assign bus.host_req_valid = r_req_valid;
  assign bus.host_req_code  = r_req.code;
  assign bus.host_req_arg0  = r_req.arg0;
  assign bus.host_req_arg1  = r_req.arg1;
  assign bus.host_rsp_ready = r_rsp_ready;
  assign bus.sys_busy       = r_busy;
  assign bus.sys_call_count = r_count;
endmodule

// File: tb/tb_sys_call_ctrl.sv
// Bench for sys_call_ctrl: directed calls with hand-computed expectations,
// then randomized traffic against a transaction-level reference model.
module tb_sys_call_ctrl;
  localparam int unsigned T    = 8;
  localparam int unsigned CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [31:0] ERR  = 32'hFFFF_FFFF;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sys_call_ctrl_if #(.CNT_W(CW)) bus ();

  sys_call_ctrl #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call in flight, described by its age since issue,
  // whether the host has taken the request, and the finished-call record.
  bit          m_busy, m_hs, m_done, m_err;
  int          m_age, m_cnt;
  logic [31:0] m_res, m_a0, m_a1;
  logic [2:0]  m_code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_hs <= 0; m_done <= 0; m_err <= 0;
      m_age <= 0; m_cnt <= 0; m_res <= '0; m_a0 <= '0; m_a1 <= '0; m_code <= '0;
    end else if (m_done) begin
      if (bus.EX__adv) m_done <= 0;
    end else if (m_busy) begin
      if (m_hs && bus.host_rsp_valid) begin
        m_busy <= 0; m_done <= 1; m_res <= bus.host_rsp_data; m_err <= 0;
        m_cnt  <= (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      end else if (m_age == int'(T) - 1) begin
        m_busy <= 0; m_done <= 1; m_res <= ERR; m_err <= 1;
        m_cnt  <= (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      end else begin
        if (bus.host_req_ready) m_hs <= 1;
        m_age <= m_age + 1;
      end
    end else if (bus.EX__sys_req) begin
      m_busy <= 1; m_hs <= 0; m_age <= 0;
      m_code <= bus.EX__sys_code; m_a0 <= bus.EX__sys_arg0; m_a1 <= bus.EX__sys_arg1;
    end
  end

  // Compare every out-of-reset cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done",      32'(bus.sys__EX_done),   32'(m_done));
      chk("result",    bus.sys__EX_result,      m_res);
      chk("err",       32'(bus.sys__EX_err),    32'(m_err));
      chk("req_valid", 32'(bus.host_req_valid), 32'(m_busy && !m_hs));
      chk("rsp_ready", 32'(bus.host_rsp_ready), 32'(m_busy && m_hs));
      chk("busy",      32'(bus.sys_busy),       32'(m_busy || m_done));
      chk("count",     32'(bus.sys_call_count), 32'(m_cnt));
      chk("req_code",  32'(bus.host_req_code),  32'(m_code));
      chk("req_arg0",  bus.host_req_arg0,       m_a0);
      chk("req_arg1",  bus.host_req_arg1,       m_a1);
    end
  end

  task automatic drive_idle();
    bus.EX__sys_req = 0; bus.EX__sys_code = '0; bus.EX__sys_arg0 = '0; bus.EX__sys_arg1 = '0;
    bus.EX__adv = 0; bus.host_req_ready = 0; bus.host_rsp_valid = 0; bus.host_rsp_data = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},  32'(bus.sys__EX_done),   32'd0);
    chk({tag, "_res"},   bus.sys__EX_result,      32'd0);
    chk({tag, "_err"},   32'(bus.sys__EX_err),    32'd0);
    chk({tag, "_valid"}, 32'(bus.host_req_valid), 32'd0);
    chk({tag, "_rrdy"},  32'(bus.host_rsp_ready), 32'd0);
    chk({tag, "_busy"},  32'(bus.sys_busy),       32'd0);
    chk({tag, "_cnt"},   32'(bus.sys_call_count), 32'd0);
    chk({tag, "_arg0"},  bus.host_req_arg0,       32'd0);
  endtask

  // One call from a negedge: host ready from cycle rdy_w, response from rsp_w
  // (both counted from ISSUE entry), EX advances after adv_w extra cycles.
  task automatic run_call(input logic [2:0] code, input logic [31:0] a0, input logic [31:0] a1,
                          input int rdy_w, input int rsp_w, input logic [31:0] data,
                          input int adv_w, input bit hold_req, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_err, input int exp_cnt);
    int lat;
    lat = -1;
    bus.EX__sys_req = 1; bus.EX__sys_code = code; bus.EX__sys_arg0 = a0; bus.EX__sys_arg1 = a1;
    bus.EX__adv = 0; bus.host_req_ready = 0; bus.host_rsp_valid = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.EX__sys_req = hold_req;
      if (bus.sys__EX_done) begin
        lat = k;
        break;
      end
      if (k <= rdy_w && k < exp_lat) begin
        chk("issue_valid", 32'(bus.host_req_valid), 32'd1);
        chk("issue_arg0",  bus.host_req_arg0, a0);
        chk("issue_arg1",  bus.host_req_arg1, a1);
      end
      bus.host_req_ready = (k >= rdy_w);
      bus.host_rsp_valid = (k >= rsp_w);
      bus.host_rsp_data  = (k >= rsp_w) ? data : 32'hDEAD_BEEF;
    end
    chk("latency",    32'(lat), 32'(exp_lat));
    chk("lit_result", bus.sys__EX_result, exp_res);
    chk("lit_err",    32'(bus.sys__EX_err), 32'(exp_err));
    chk("lit_count",  32'(bus.sys_call_count), 32'(exp_cnt));
    bus.host_req_ready = 0; bus.host_rsp_valid = 0;
    for (int j = 0; j < adv_w; j++) begin
      bus.EX__adv = 0;
      @(negedge clk);
      chk("done_held",  32'(bus.sys__EX_done), 32'd1);
      chk("count_held", 32'(bus.sys_call_count), 32'(exp_cnt));
    end
    bus.EX__adv = 1;
    @(negedge clk);
    chk("done_drop", 32'(bus.sys__EX_done), 32'd0);
    bus.EX__adv = 0; bus.EX__sys_req = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 0;
    drive_idle();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;

    // code, a0, a1, rdy, rsp, data, adv, hold, lat, result, err, count
    run_call(3'b000, 32'h41, 32'h0, 0, 1, 32'h1, 0, 0, 2, 32'h1, 0, 1);
    run_call(3'b010, 32'hA5A5_0001, 32'h1234_5678, 5, 6, 32'h55, 1, 0, 7, 32'h55, 0, 2);
    run_call(3'b001, 32'h7, 32'h9, 0, 99, 32'h0, 0, 0, 8, ERR, 1, 3);
    run_call(3'b011, 32'h8, 32'hA, 99, 99, 32'h0, 0, 0, 8, ERR, 1, 4);
    run_call(3'b100, 32'hB, 32'hC, 0, 7, 32'h1234, 0, 0, 8, 32'h1234, 0, 5);
    run_call(3'b101, 32'hD, 32'hE, 0, 6, 32'hCAFE, 3, 1, 7, 32'hCAFE, 0, 6);
    run_call(3'b110, 32'hF, 32'h10, 0, 1, 32'hBEEF, 0, 0, 2, 32'hBEEF, 0, 7);
    run_call(3'b111, 32'h11, 32'h12, 0, 1, 32'h77, 0, 0, 2, 32'h77, 0, 7);

    // Asynchronous reset while waiting for the host
    bus.EX__sys_req = 1; bus.EX__sys_code = 3'b010; bus.EX__sys_arg0 = 32'h99; bus.host_req_ready = 1;
    @(negedge clk);
    bus.EX__sys_req = 0;
    @(negedge clk);
    chk("wait_rsp_ready", 32'(bus.host_rsp_ready), 32'd1);
    #2 rst_n = 0;
    #1 chk_all_zero("async_rst");
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_call(3'b000, 32'h42, 32'h1, 1, 2, 32'h5, 0, 0, 3, 32'h5, 0, 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.EX__sys_req    = ($urandom_range(0, 2) != 0);
      bus.EX__sys_code   = 3'($urandom);
      bus.EX__sys_arg0   = $urandom;
      bus.EX__sys_arg1   = $urandom;
      bus.EX__adv        = ($urandom_range(0, 2) == 0);
      bus.host_req_ready = ($urandom_range(0, 2) != 0);
      bus.host_rsp_valid = ($urandom_range(0, 4) == 0);
      bus.host_rsp_data  = $urandom;
    end
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
